jt1943_sdram: RTL
=================

# jt1943_sdram

SDRAM controller directly downstream of the ROM request arbiter. It turns each `sdram_re` edge plus `sdram_addr` into a 2-word burst read and returns 32-bit `data_read` within a fixed slot. It also performs power-up initialisation, periodic auto-refresh and 16-bit ROM download writes. It drives the single SDR SDRAM chip: 13-bit row, 9-bit column, bank 0 only.

## Interface
Parameters:
- `INIT_WAIT`, 9600: clk cycles of power-up wait (100 µs at 96 MHz).
- `REF_PERIOD`, 749: clk cycles between refresh credits (7.8 µs).
- `REF_MAX`, 7: saturation value of the pending-refresh counter.

Ports:
- `clk` in 1: SDRAM clock, 96 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `loop_rst` out 1: high during reset and the init sequence; arbiter holds off.
- `sdram_re` in 1: any edge requests a read.
- `sdram_addr` in 22: word address; [21:9] row, [8:0] column.
- `data_read` out 32: {word at addr+1, word at addr}.
- `downloading` in 1: download mode; reads are ignored.
- `prog_we` in 1: one-cycle write strobe.
- `prog_addr` in 22: write word address.
- `prog_data` in 16: write data.
- `prog_mask` in 2: active-low byte enables {hi, lo}.
- `prog_rdy` out 1: one-cycle pulse when a write completes.
- `SDRAM_DQ` inout 16: data bus.
- `SDRAM_A` out 13: address bus.
- `SDRAM_BA` out 2: bank select, always 0.
- `SDRAM_nCS`, `SDRAM_nRAS`, `SDRAM_nCAS`, `SDRAM_nWE` out 1 each: command pins.
- `SDRAM_DQML`, `SDRAM_DQMH` out 1 each: byte masks.
- `SDRAM_CKE` out 1: clock enable.

## Operation
- Reset values:
  - `loop_rst`=1, `data_read`=0, `prog_rdy`=0, command=NOP (nCS=0, others 1).
  - `SDRAM_A`=0, DQM=2'b11, DQ high-Z.
  - `SDRAM_CKE`=1; all counters 0; state INIT_WAIT.
- Init states: INIT_WAIT (`INIT_WAIT` cycles) → INIT_PRE (PRECHARGE ALL, A10=1, 2 cycles) → INIT_REF ×2 (AUTO REFRESH, 8 cycles each) → INIT_MRS.
- INIT_MRS loads mode 13'h021: burst length 2, sequential, CL=2, burst write. After 2 cycles it enters IDLE and clears `loop_rst`.
- Edge detect: `sdram_re` is registered, and `re_d ^ sdram_re` marks a request. Edges are ignored while `downloading` or `loop_rst` is high.
- READ slot, numbered from the edge-detect cycle c0:
  - c1: ACTIVE with row.
  - c3: READ with A10=1 (auto-precharge) and column.
  - c5/c6: capture DQ low/high.
  - c7: update `data_read`.
  - c9: back in IDLE.
- Refresh credit counter: +1 every `REF_PERIOD`, saturating at `REF_MAX`.
  - In IDLE with no edge pending and credit>0, issue AUTO REFRESH (7 cycles), then decrement.
  - A read edge arriving during refresh is latched and served right after it.
- WRITE (only while `downloading`): `prog_we` latched.
  - ACTIVE, then WRITE with AP two cycles later; DQ driven for 1 cycle; DQML/DQMH=`prog_mask`.
  - `prog_rdy` pulses 4 cycles after WRITE; then IDLE.
  - Refresh takes priority over a pending write; the write is never dropped.
- Columns do not wrap within a row: a read at column 511 is illegal for the arbiter and yields an undefined upper word.
- A new edge during an active read slot is latched (one-deep) and served next; a second edge before then is a protocol error and is ignored.
- Asserting `rst` mid-burst aborts immediately and restarts full init.

## Timing
- Edge to `data_read` update: 8 clk. The value holds until the next read completes.
- `sdram_re` edges arrive no more than once per 16 clk. A read (9) plus a refresh (7) fits one slot, so sustained reads never starve refresh.
- tRCD = 2 clk, CL = 2, tRP/auto-precharge ≥ 2 clk, tRFC = 7 clk.
- Command pins, `SDRAM_A` and DQ output enable are all registered outputs.

## Structure
- Package `jt1943_sdram_pkg`:
  - command encodings {nRAS,nCAS,nWE}: NOP, ACTIVE, READ, WRITE, PRECHARGE, REFRESH, MRS;
  - mode word, tRCD/CL/tRFC constants;
  - state enum.
- Sub-module `jt1943_sdram_refcnt`: period counter plus saturating credit counter, with `ref_req` out and `ref_ack` in.
- The main module holds the edge detector, the state machine with its cycle counter, and the DQ tristate.

## Test plan
- Reset release → `loop_rst` high for INIT_WAIT+22 clk; bus shows PRE, REF, REF, MRS with A=13'h021; then `loop_rst`=0.
- Model preloaded with 0x1234 @ 0x00A00 and 0xABCD @ 0x00A01; toggle `sdram_re` with addr 0x00A00 → ACTIVE row 5, READ col 0 at c3; `data_read`=32'hABCD1234 at c7.
- Edges every 16 clk for 2 ms → no refresh credit ever reaches `REF_MAX`; all reads return correct data.
- `downloading`=1, `prog_we` with addr 0x3FFFFF, data 0x55AA, mask 2'b10 → only the low byte is written; `prog_rdy` pulses once.
- `sdram_re` edge while a refresh is in progress → READ issued right after tRFC; `data_read` correct.
- `rst` asserted at c4 of a read → outputs back to reset values immediately; full init repeats.

Source files
------------

// File: rtl/jt1943_sdram_pkg.sv
// jt1943_sdram_pkg: SDRAM command encodings, timing constants and controller states
package jt1943_sdram_pkg;
  typedef enum logic [2:0] {
    CMD_MRS       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_NOP       = 3'b111
  } cmd_t;
  localparam logic [12:0] MODE_WORD = 13'h021;
  localparam logic [15:0] T_RCD = 16'd2;
  localparam logic [15:0] T_CL  = 16'd2;
  localparam logic [15:0] T_RFC = 16'd7;
  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_MRS,
    S_IDLE,
    S_READ,
    S_WRITE,
    S_REF
  } state_t;
endpackage

// File: rtl/jt1943_sdram_refcnt.sv
// jt1943_sdram_refcnt: refresh period timer with a saturating pending-refresh credit counter
module jt1943_sdram_refcnt #(
  parameter int REF_PERIOD = 749,
  parameter int REF_MAX    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ref_ack,
  output logic ref_req
);
  localparam int CW = $clog2(REF_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(REF_MAX);
  logic [15:0]   per;
  logic [CW-1:0] credit;
  logic          tick, inc;
  assign tick    = en && per == 16'(REF_PERIOD - 1);
  assign inc     = tick && credit != MAXV;
  assign ref_req = credit != '0;
  // period timer earns one credit per tick; each completed refresh spends one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per    <= 16'd0;
      credit <= '0;
    end else begin
      per <= (!en || tick) ? 16'd0 : per + 16'd1;
      if (inc && !ref_ack) credit <= credit + 1'b1;
      else if (!inc && ref_ack) credit <= credit - 1'b1;
    end
  end
endmodule

// File: rtl/jt1943_sdram.sv
// jt1943_sdram: SDR SDRAM controller for 2-word burst reads, init, auto-refresh and download writes
module jt1943_sdram
  import jt1943_sdram_pkg::*;
#(
  parameter int INIT_WAIT  = 9600,
  parameter int REF_PERIOD = 749,
  parameter int REF_MAX    = 7
) (
  input  logic        clk,
  input  logic        rst,
  output logic        loop_rst,
  input  logic        sdram_re,
  input  logic [21:0] sdram_addr,
  output logic [31:0] data_read,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  output logic        prog_rdy,
  inout  wire  [15:0] SDRAM_DQ,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic        SDRAM_nCS,
  output logic        SDRAM_nRAS,
  output logic        SDRAM_nCAS,
  output logic        SDRAM_nWE,
  output logic        SDRAM_DQML,
  output logic        SDRAM_DQMH,
  output logic        SDRAM_CKE
);
  logic [1:0]  rs;
  logic        rst_s, re_d, req, rd_pend, wr_pend, ref_req, ref_ack, dq_oe;
  state_t      state;
  cmd_t        cmd;
  logic [15:0] cnt, wr_data, dq_out, lo;
  logic [21:0] pend_addr, nxt, wr_addr;
  logic [8:0]  col;
  logic [1:0]  wr_mask, dqm;
  assign rst_s    = rs[1];
  assign req      = (re_d ^ sdram_re) && !downloading && !loop_rst;
  assign nxt      = rd_pend ? pend_addr : sdram_addr;
  assign ref_ack  = state == S_REF && cnt == T_RFC - 16'd1;
  assign SDRAM_DQ = dq_oe ? dq_out : 16'hzzzz;
  assign {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd;
  assign {SDRAM_DQMH, SDRAM_DQML} = dqm;
  assign SDRAM_nCS = 1'b0;
  assign SDRAM_BA  = 2'b00;
  assign SDRAM_CKE = 1'b1;
  // reset asserts at once but releases two clocks later, in step with clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rs <= 2'b11;
    else rs <= {rs[0], 1'b0};
  end
  jt1943_sdram_refcnt #(.REF_PERIOD(REF_PERIOD), .REF_MAX(REF_MAX)) u_ref (
    .clk(clk), .rst(rst_s), .en(!loop_rst), .ref_ack(ref_ack), .ref_req(ref_req)
  );
  // command sequencer: init, then reads beat refresh, refresh beats writes
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state     <= S_INIT_WAIT;
      cmd       <= CMD_NOP;
      cnt       <= 16'd0;
      loop_rst  <= 1'b1;
      data_read <= 32'd0;
      prog_rdy  <= 1'b0;
      SDRAM_A   <= 13'd0;
      dqm       <= 2'b11;
      dq_oe     <= 1'b0;
      dq_out    <= 16'd0;
      re_d      <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      pend_addr <= 22'd0;
      wr_addr   <= 22'd0;
      wr_data   <= 16'd0;
      wr_mask   <= 2'b11;
      col       <= 9'd0;
      lo        <= 16'd0;
    end else begin
      re_d     <= sdram_re;
      cmd      <= CMD_NOP;
      cnt      <= cnt + 16'd1;
      prog_rdy <= 1'b0;
      if (req && !rd_pend) begin
        rd_pend   <= 1'b1;
        pend_addr <= sdram_addr;
      end
      if (prog_we && downloading) begin
        wr_pend <= 1'b1;
        wr_addr <= prog_addr;
        wr_data <= prog_data;
        wr_mask <= prog_mask;
      end
      case (state)
        S_INIT_WAIT: if (cnt == 16'(INIT_WAIT - 1)) begin
          state   <= S_INIT_PRE;
          cnt     <= 16'd0;
          cmd     <= CMD_PRECHARGE;
          SDRAM_A <= 13'h0400;
        end
        S_INIT_PRE: if (cnt == 16'd1) begin
          state <= S_INIT_REF1;
          cnt   <= 16'd0;
          cmd   <= CMD_REFRESH;
        end
        S_INIT_REF1: if (cnt == 16'd7) begin
          state <= S_INIT_REF2;
          cnt   <= 16'd0;
          cmd   <= CMD_REFRESH;
        end
        S_INIT_REF2: if (cnt == 16'd7) begin
          state   <= S_INIT_MRS;
          cnt     <= 16'd0;
          cmd     <= CMD_MRS;
          SDRAM_A <= MODE_WORD;
        end
        S_INIT_MRS: if (cnt == 16'd1) begin
          state    <= S_IDLE;
          loop_rst <= 1'b0;
        end
        S_IDLE: begin
          cnt <= 16'd0;
          if (req || rd_pend) begin
            state   <= S_READ;
            cmd     <= CMD_ACTIVE;
            SDRAM_A <= nxt[21:9];
            col     <= nxt[8:0];
            rd_pend <= rd_pend && req;
            if (req) pend_addr <= sdram_addr;
          end else if (ref_req) begin
            state <= S_REF;
            cmd   <= CMD_REFRESH;
          end else if (wr_pend) begin
            state   <= S_WRITE;
            cmd     <= CMD_ACTIVE;
            SDRAM_A <= wr_addr[21:9];
            wr_pend <= 1'b0;
          end
        end
        S_READ: begin
          if (cnt == T_RCD - 16'd1) begin
            cmd     <= CMD_READ;
            SDRAM_A <= {4'b0010, col};
          end
          if (cnt == T_RCD + T_CL) lo <= SDRAM_DQ;
          if (cnt == T_RCD + T_CL + 16'd1) data_read <= {SDRAM_DQ, lo};
          if (cnt == T_RCD + T_CL + 16'd3) state <= S_IDLE;
        end
        S_WRITE: begin
          if (cnt == T_RCD - 16'd1) begin
            cmd     <= CMD_WRITE;
            SDRAM_A <= {4'b0010, wr_addr[8:0]};
            dq_oe   <= 1'b1;
            dq_out  <= wr_data;
            dqm     <= wr_mask;
          end
          if (cnt == T_RCD) begin
            dq_oe <= 1'b0;
            dqm   <= 2'b11;
          end
          if (cnt == T_RCD + 16'd3) prog_rdy <= 1'b1;
          if (cnt == T_RCD + 16'd4) state <= S_IDLE;
        end
        S_REF: if (ref_ack) state <= S_IDLE;
        default: state <= S_INIT_WAIT;
      endcase
    end
  end
endmodule
